// File: rtl/special_case_detector_for_divider.sv
// rtl/special_case_detector_for_divider.sv - two-stage valid/ready classifier of HUB divider operands
// Stage 1 registers operands and raw exponent/mantissa flags; stage 2 encodes case codes.
module special_case_detector_for_divider #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7,
  parameter int CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [E+M:0]                     X,
  input  logic [E+M:0]                     Y,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [E+M:0]                     X_out,
  output logic [E+M:0]                     Y_out,
  output logic [$clog2(special_case)-1:0]  X_special_case,
  output logic [$clog2(special_case)-1:0]  Y_special_case,
  output logic                             is_special,
  input  logic                             cnt_clear,
  output logic [CNT_W-1:0]                 special_count
);

  localparam int W = E + M + 1;
  localparam int C = $clog2(special_case);

  localparam logic [C-1:0] NONE   = C'(0);
  localparam logic [C-1:0] INF_P  = C'(1);
  localparam logic [C-1:0] INF_N  = C'(2);
  localparam logic [C-1:0] ZERO_P = C'(3);
  localparam logic [C-1:0] ZERO_N = C'(4);
  localparam logic [C-1:0] ONE_P  = C'(5);
  localparam logic [C-1:0] ONE_N  = C'(6);

  localparam logic [E-1:0]     BIAS    = {1'b0, {(E-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [C-1:0] encode(input logic sgn, input logic inf,
                                          input logic zero, input logic one);
    logic [C-1:0] code;
    code = NONE;
    if (inf)       code = sgn ? INF_N  : INF_P;
    else if (zero) code = sgn ? ZERO_N : ZERO_P;
    else if (one)  code = sgn ? ONE_N  : ONE_P;
    return code;
  endfunction

  logic         s1_valid;
  logic [W-1:0] s1_x, s1_y;
  logic         s1_x_inf, s1_x_zero, s1_x_one;
  logic         s1_y_inf, s1_y_zero, s1_y_one;

  logic s2_load, s1_move, accept;
  logic [C-1:0] x_code_d, y_code_d;

  // Stage 2 frees up whenever it is empty or its pair leaves this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign s1_move  = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_move;
  assign accept   = in_valid && in_ready;

  assign x_code_d = encode(s1_x[W-1], s1_x_inf, s1_x_zero, s1_x_one);
  assign y_code_d = encode(s1_y[W-1], s1_y_inf, s1_y_zero, s1_y_one);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_x_inf  <= 1'b0;
      s1_x_zero <= 1'b0;
      s1_x_one  <= 1'b0;
      s1_y_inf  <= 1'b0;
      s1_y_zero <= 1'b0;
      s1_y_one  <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_x      <= X;
        s1_y      <= Y;
        s1_x_inf  <= &X[W-2:M];
        s1_x_zero <= ~|X[W-2:M];
        s1_x_one  <= (X[W-2:M] == BIAS) && (X[M-1:0] == '0);
        s1_y_inf  <= &Y[W-2:M];
        s1_y_zero <= ~|Y[W-2:M];
        s1_y_one  <= (Y[W-2:M] == BIAS) && (Y[M-1:0] == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      X_out          <= '0;
      Y_out          <= '0;
      X_special_case <= NONE;
      Y_special_case <= NONE;
      is_special     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        X_out          <= s1_x;
        Y_out          <= s1_y;
        X_special_case <= x_code_d;
        Y_special_case <= y_code_d;
        is_special     <= (x_code_d != NONE) || (y_code_d != NONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      special_count <= '0;
    end else if (cnt_clear) begin
      special_count <= '0;
    end else if (out_valid && out_ready && is_special && special_count != CNT_MAX) begin
      special_count <= special_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_special_case_detector_for_divider.sv
// tb/tb_special_case_detector_for_divider.sv - randomized bench with a queue-based reference model
module tb_special_case_detector_for_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clear = 1'b0;
  logic [31:0] X = '0, Y = '0;

  logic        in_ready, out_valid, is_special;
  logic [31:0] X_out, Y_out;
  logic [2:0]  X_special_case, Y_special_case;
  logic [15:0] special_count;

  logic        in_ready2, out_valid2, is_special2;
  logic [31:0] X_out2, Y_out2;
  logic [2:0]  X_special_case2, Y_special_case2;
  logic [1:0]  special_count2;

  special_case_detector_for_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .X_out(X_out), .Y_out(Y_out), .X_special_case(X_special_case),
    .Y_special_case(Y_special_case), .is_special(is_special),
    .cnt_clear(cnt_clear), .special_count(special_count)
  );

  special_case_detector_for_divider #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .X(X), .Y(Y), .out_valid(out_valid2), .out_ready(out_ready),
    .X_out(X_out2), .Y_out(Y_out2), .X_special_case(X_special_case2),
    .Y_special_case(Y_special_case2), .is_special(is_special2),
    .cnt_clear(cnt_clear), .special_count(special_count2)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference classification straight from the encoding rules.
  function automatic int cls(input logic [31:0] v);
    int ex;
    ex = int'(v[30:23]);
    if (ex == 255) return v[31] ? 2 : 1;
    if (ex == 0) return v[31] ? 4 : 3;
    if (ex == 127 && v[22:0] == 0) return v[31] ? 6 : 5;
    return 0;
  endfunction

  logic [31:0] xq[$], yq[$];
  int          aq[$];
  int          edges = 0;
  int          cnt16 = 0, cnt2 = 0;

  always @(posedge clk) edges++;

  always @(negedge clk) begin
    bit exp_ov, xfer, acc, spec;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", special_count, 0);
      chk("rst_codes", {X_special_case, Y_special_case, is_special}, 0);
      chk("rst_data", {X_out, Y_out}, 0);
      chk("rst_count2", special_count2, 0);
      xq.delete(); yq.delete(); aq.delete();
      cnt16 = 0; cnt2 = 0;
    end else begin
      exp_ov = (xq.size() > 0) && (aq[0] <= edges - 1);
      chk("out_valid", out_valid, exp_ov);
      chk("out_valid2", out_valid2, exp_ov);
      chk("in_ready", in_ready, (xq.size() < 2) || out_ready);
      chk("in_ready2", in_ready2, (xq.size() < 2) || out_ready);
      if (exp_ov) begin
        spec = (cls(xq[0]) != 0) || (cls(yq[0]) != 0);
        chk("X_out", X_out, xq[0]);
        chk("Y_out", Y_out, yq[0]);
        chk("X_code", X_special_case, cls(xq[0]));
        chk("Y_code", Y_special_case, cls(yq[0]));
        chk("is_special", is_special, spec);
        chk("X_code2", X_special_case2, cls(xq[0]));
      end
      chk("special_count", special_count, cnt16);
      chk("special_count2", special_count2, cnt2);

      xfer = exp_ov && out_ready;
      acc  = in_valid && ((xq.size() < 2) || out_ready);
      spec = 0;
      if (xfer) begin
        spec = (cls(xq[0]) != 0) || (cls(yq[0]) != 0);
        void'(xq.pop_front()); void'(yq.pop_front()); void'(aq.pop_front());
      end
      if (cnt_clear) begin
        cnt16 = 0; cnt2 = 0;
      end else if (xfer && spec) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt2 < 3) cnt2++;
      end
      if (acc) begin
        xq.push_back(X); yq.push_back(Y); aq.push_back(edges + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0]  ex;
    logic [22:0] mn;
    case ($urandom % 5)
      0: ex = 8'h00;
      1: ex = 8'hFF;
      2: ex = 8'h7F;
      3: ex = 8'h7E;
      default: ex = 8'($urandom);
    endcase
    mn = ($urandom % 2) ? 23'd0 : 23'($urandom);
    return {1'($urandom), ex, mn};
  endfunction

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Literal pair: 1.0 / +0 -> ONE_P, ZERO_P after two edges.
    in_valid = 1; X = 32'h3F800000; Y = 32'h00000000;
    tick();
    in_valid = 0;
    chk("lit1_not_yet", out_valid, 0);
    tick();
    chk("lit1_valid", out_valid, 1);
    chk("lit1_codes", {X_special_case, Y_special_case, is_special}, {3'd5, 3'd3, 1'b1});
    tick();
    chk("lit1_count", special_count, 1);

    in_valid = 1; X = 32'h7FFFFFFF; Y = 32'hFFFFFFFF;
    tick();
    X = 32'h40490FDB; Y = 32'hC0000000;
    tick();
    in_valid = 0;
    chk("lit2_codes", {X_special_case, Y_special_case, is_special}, {3'd1, 3'd2, 1'b1});
    tick();
    chk("lit3_codes", {X_special_case, Y_special_case, is_special}, {3'd0, 3'd0, 1'b0});
    chk("lit2_count", special_count, 2);
    tick();
    chk("lit3_count", special_count, 2);

    // Backpressure: two accepts then stall with both stages full.
    out_ready = 0; in_valid = 1; X = 32'h3F800000; Y = 32'h12345678;
    tick();
    X = 32'hBF800000; Y = 32'h80000000;
    tick();
    chk("bp_in_ready_low", in_ready, 0);
    X = 32'h11111111; Y = 32'h22222222;
    repeat (4) begin
      tick();
      chk("bp_hold_X", X_out, 32'h3F800000);
    end
    out_ready = 1; in_valid = 0;
    #1 chk("bp_first", X_out, 32'h3F800000);
    tick();
    chk("bp_second", {X_out, X_special_case}, {32'hBF800000, 3'd6});
    tick();

    // Reset with both stages full.
    out_ready = 0; in_valid = 1; X = 32'h7F800000; Y = 32'h0;
    tick(); tick();
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", special_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1; out_ready = 1;
    tick();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Saturation of the 2-bit counter, then clear beating an increment.
    in_valid = 1; X = 32'h00000000; Y = 32'h3F800000;
    repeat (5) tick();
    in_valid = 0;
    tick(); tick(); tick();
    chk("sat_count2", special_count2, 3);
    chk("sat_count16", special_count, 5);
    in_valid = 1; X = 32'hFF800000; Y = 32'h40000000;
    tick();
    in_valid = 0;
    tick();
    chk("clr_pending", {out_valid, is_special}, 2'b11);
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    chk("clr_count2", special_count2, 0);
    chk("clr_count16", special_count, 0);

    // Random valid/ready traffic with a single mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      cnt_clear = ($urandom % 64) == 0;
      X = rnd_op();
      Y = rnd_op();
      if (i == 1000) rst_n = 0;
      if (i == 1002) rst_n = 1;
      tick();
    end
    in_valid = 0; out_ready = 1; cnt_clear = 0;
    repeat (4) tick();
    chk("drain_empty", xq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
